keypad_event_ctrl: RTL and testbench

//  Sequencer for the hex keypad scanner. Paces the scanner with a clock-enable tick.

---
 rtl/keypad_event_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_keypad_event_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_event_ctrl.sv
// Hex keypad sequencer: scan pacing, press/release debounce, key event FIFO.
// Optional auto-repeat while a key is held is built when KEYPAD_REPEAT_EN is defined.
module keypad_event_ctrl #(
   parameter int SCAN_DIV     = 16,
   parameter int DEBOUNCE_CYC = 8,
   parameter int FIFO_DEPTH   = 4
`ifdef KEYPAD_REPEAT_EN
   ,
   parameter int REPEAT_DLY   = 64,
   parameter int REPEAT_RATE  = 16
`endif
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          enable,
   output logic                          scan_tick,
   input  logic                          kp_valid,
   input  logic [3:0]                    kp_code,
   input  logic                          kp_pressed,
   output logic                          key_valid,
   output logic [3:0]                    key_code,
   input  logic                          key_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   input  logic                          ovf_clr
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DW = $clog2(DEBOUNCE_CYC + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
   localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

   // ------------------------------------------------------------------
   // Scan prescaler
   // ------------------------------------------------------------------
   logic [PW-1:0] pre_cnt;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pre_cnt <= '0;
      end else if (!enable) begin
         pre_cnt <= '0;
      end else if (pre_cnt == PRE_LAST) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end

   assign scan_tick = enable && (pre_cnt == PRE_LAST);

   // ------------------------------------------------------------------
   // Debounce / event FSM
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PRESS_DB = 2'd1,
      HELD     = 2'd2,
      REL_DB   = 2'd3
   } state_t;

   state_t        state;
   logic [DW-1:0] dcnt;
   logic [3:0]    cand;
   logic          push;
   logic          rpt_hit;

`ifdef KEYPAD_REPEAT_EN
   localparam int RW = $clog2(REPEAT_DLY + REPEAT_RATE + 1);
   localparam logic [RW-1:0] RPT_FIRST = RW'(REPEAT_DLY - 1);
   localparam logic [RW-1:0] RPT_NEXT  = RW'(REPEAT_DLY + REPEAT_RATE - 1);
   localparam logic [RW-1:0] RPT_BASE  = RW'(REPEAT_DLY);

   logic [RW-1:0] rcnt;

   // rcnt counts held ticks; after the first repeat it cycles REPEAT_DLY..REPEAT_DLY+REPEAT_RATE-1
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rcnt <= '0;
      end else if (!enable || state != HELD) begin
         rcnt <= '0;
      end else if (scan_tick) begin
         if (!kp_pressed) begin
            rcnt <= '0;
         end else if (rcnt == RPT_NEXT) begin
            rcnt <= RPT_BASE;
         end else begin
            rcnt <= rcnt + RW'(1);
         end
      end
   end

   assign rpt_hit = (state == HELD) && scan_tick && kp_pressed &&
                    ((rcnt == RPT_FIRST) || (rcnt == RPT_NEXT));
`else
   assign rpt_hit = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         dcnt  <= '0;
         cand  <= 4'h0;
         push  <= 1'b0;
      end else begin
         push <= 1'b0;
         if (!enable) begin
            state <= IDLE;
            dcnt  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (kp_valid) begin
                     cand  <= kp_code;
                     dcnt  <= '0;
                     state <= PRESS_DB;
                  end
               end
               PRESS_DB: begin
                  // A different code during qualification restarts on the new key
                  if (kp_valid && (kp_code != cand)) begin
                     cand <= kp_code;
                     dcnt <= '0;
                  end else if (scan_tick) begin
                     if (!kp_pressed) begin
                        state <= IDLE;
                        dcnt  <= '0;
                     end else if (dcnt == DB_LAST) begin
                        push  <= 1'b1;
                        state <= HELD;
                        dcnt  <= '0;
                     end else begin
                        dcnt <= dcnt + DW'(1);
                     end
                  end
               end
               HELD: begin
                  if (scan_tick) begin
                     if (!kp_pressed) begin
                        state <= REL_DB;
                        dcnt  <= '0;
                     end else if (rpt_hit) begin
                        push <= 1'b1;
                     end
                  end
               end
               REL_DB: begin
                  if (scan_tick) begin
                     if (kp_pressed) begin
                        state <= HELD;
                        dcnt  <= '0;
                     end else if (dcnt == DB_LAST) begin
                        state <= IDLE;
                        dcnt  <= '0;
                     end else begin
                        dcnt <= dcnt + DW'(1);
                     end
                  end
               end
               default: begin
                  state <= IDLE;
                  dcnt  <= '0;
               end
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // Key event FIFO
   // ------------------------------------------------------------------
   logic [3:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [LW-1:0] level;
   logic          full;
   logic          do_pop;
   logic          do_push;

   assign full    = (level == LVL_FULL);
   assign do_pop  = key_valid && key_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= cand;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (do_push && !do_pop) begin
            level <= level + LW'(1);
         end else if (do_pop && !do_push) begin
            level <= level - LW'(1);
         end
         if (push && !do_push) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
      end
   end

   assign key_valid  = (level != '0);
   assign key_code   = key_valid ? mem[rd_ptr] : 4'h0;
   assign fifo_level = level;

endmodule

// File: tb/tb_keypad_event_ctrl.sv
// Scoreboard bench for keypad_event_ctrl: expected codes queued at stimulus, compared at pop.
module tb_keypad_event_ctrl;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       enable = 1'b0;
   logic       kp_valid = 1'b0;
   logic [3:0] kp_code = 4'h0;
   logic       kp_pressed = 1'b0;
   logic       key_ready = 1'b0;
   logic       ovf_clr = 1'b0;
   logic       scan_tick;
   logic       key_valid;
   logic [3:0] key_code;
   logic [2:0] fifo_level;
   logic       overflow;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [3:0] exp_q[$];
   logic       exp_ovf = 1'b0;

   keypad_event_ctrl dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .scan_tick  (scan_tick),
      .kp_valid   (kp_valid),
      .kp_code    (kp_code),
      .kp_pressed (kp_pressed),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_ready  (key_ready),
      .fifo_level (fifo_level),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   // Returns in the cycle after the n-th scan_tick edge
   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         int guard;
         guard = 0;
         while (!scan_tick && guard < 100) begin
            cyc();
            guard++;
         end
         if (!scan_tick) begin
            check("tick_timeout", 32'd0, 32'd1);
            return;
         end
         cyc();
      end
   endtask

   task automatic start_press(input logic [3:0] code);
      kp_code    = code;
      kp_valid   = 1'b1;
      kp_pressed = 1'b1;
      cyc();
      kp_valid   = 1'b0;
   endtask

   task automatic press_key(input logic [3:0] code, input int hold);
      start_press(code);
      if (hold >= 8) begin
         if (exp_q.size() < 4) exp_q.push_back(code);
         else exp_ovf = 1'b1;
      end
      wait_ticks(hold);
      kp_pressed = 1'b0;
      wait_ticks(10);
      cyc();
      $display("press code=%h hold=%0d level=%0d", code, hold, fifo_level);
   endtask

   task automatic drain(input string tag);
      int guard;
      logic [3:0] e;
      guard = 0;
      key_ready = 1'b1;
      while ((key_valid || exp_q.size() > 0) && guard < 50) begin
         if (key_valid) begin
            if (exp_q.size() == 0) begin
               check({tag, "_extra_pop"}, 32'(key_code), 32'hFFFF);
            end else begin
               e = exp_q.pop_front();
               $display("pop %s code=%h expect=%h", tag, key_code, e);
               check({tag, "_code"}, 32'(key_code), 32'(e));
            end
         end
         cyc();
         guard++;
      end
      key_ready = 1'b0;
      check({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
      check({tag, "_empty_valid"}, 32'(key_valid), 32'd0);
      check({tag, "_empty_level"}, 32'(fifo_level), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int n;
      int ticks;
      int guard;
      logic [2:0] prev;
      logic [3:0] e;
      int exp_ticks[$];
      int got_ticks[$];

      // T1: reset values, then first scan_tick timing
      repeat (3) cyc();
      check("rst_scan_tick", 32'(scan_tick), 32'd0);
      check("rst_key_valid", 32'(key_valid), 32'd0);
      check("rst_key_code", 32'(key_code), 32'd0);
      check("rst_level", 32'(fifo_level), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      reset = 1'b1;
      cyc();
      enable = 1'b1;
      n = 1;
      while (!scan_tick && n < 100) begin
         cyc();
         n++;
      end
      check("first_tick_cycle", 32'(n), 32'd16);
      cyc();

      // T2: valid press of 0xA
      start_press(4'hA);
      exp_q.push_back(4'hA);
      wait_ticks(8);
      check("t2_level_pre_push", 32'(fifo_level), 32'd0);
      cyc();
      check("t2_level", 32'(fifo_level), 32'd1);
      check("t2_valid", 32'(key_valid), 32'd1);
      check("t2_code", 32'(key_code), 32'hA);
      kp_pressed = 1'b0;
      wait_ticks(10);
      check("t2_single_event", 32'(fifo_level), 32'd1);

      // T3: bounce after 3 ticks gives no event
      press_key(4'h5, 3);
      check("t3_level", 32'(fifo_level), 32'd1);
      drain("t2");

      // T4: five presses into a four-entry FIFO
      for (int c = 1; c <= 5; c++) press_key(4'(c), 8);
      check("t4_level", 32'(fifo_level), 32'd4);
      check("t4_overflow", 32'(overflow), 32'(exp_ovf));
      drain("t4");
      check("t4_ovf_sticky", 32'(overflow), 32'd1);
      ovf_clr = 1'b1;
      cyc();
      ovf_clr = 1'b0;
      exp_ovf = 1'b0;
      check("t4_ovf_clr", 32'(overflow), 32'd0);

      // T5: push and pop in the same cycle while full
      for (int c = 6; c <= 9; c++) press_key(4'(c), 8);
      start_press(4'hB);
      wait_ticks(8);
      check("t5_full_level", 32'(fifo_level), 32'd4);
      key_ready = 1'b1;
      e = exp_q.pop_front();
      check("t5_pop_code", 32'(key_code), 32'(e));
      exp_q.push_back(4'hB);
      cyc();
      key_ready = 1'b0;
      check("t5_level", 32'(fifo_level), 32'd4);
      check("t5_no_overflow", 32'(overflow), 32'd0);
      kp_pressed = 1'b0;
      wait_ticks(10);
      drain("t5");

      // T6: key 7 held for 100 ticks
`ifdef KEYPAD_REPEAT_EN
      exp_ticks.push_back(8);
      exp_ticks.push_back(72);
      exp_ticks.push_back(88);
`else
      exp_ticks.push_back(8);
`endif
      foreach (exp_ticks[i]) exp_q.push_back(4'h7);
      start_press(4'h7);
      ticks = 0;
      guard = 0;
      prev  = fifo_level;
      while (ticks < 100 && guard < 3000) begin
         if (scan_tick) ticks++;
         cyc();
         guard++;
         if (fifo_level > prev) got_ticks.push_back(ticks);
         prev = fifo_level;
      end
      check("t6_hold_done", 32'(ticks), 32'd100);
      kp_pressed = 1'b0;
      wait_ticks(10);
      check("t6_event_count", 32'(got_ticks.size()), 32'(exp_ticks.size()));
      for (int i = 0; i < exp_ticks.size() && i < got_ticks.size(); i++) begin
         $display("event %0d at tick %0d", i, got_ticks[i]);
         check("t6_event_tick", 32'(got_ticks[i]), 32'(exp_ticks[i]));
      end
      drain("t6");

      // Asynchronous reset mid-debounce with FIFO data and a live scan_tick
      press_key(4'hC, 8);
      start_press(4'h4);
      wait_ticks(2);
      guard = 0;
      while (!scan_tick && guard < 100) begin
         cyc();
         guard++;
      end
      check("mid_pre_valid", 32'(key_valid), 32'd1);
      check("mid_pre_tick", 32'(scan_tick), 32'd1);
      reset = 1'b0;
      #1;
      check("mid_scan_tick", 32'(scan_tick), 32'd0);
      check("mid_key_valid", 32'(key_valid), 32'd0);
      check("mid_key_code", 32'(key_code), 32'd0);
      check("mid_level", 32'(fifo_level), 32'd0);
      check("mid_overflow", 32'(overflow), 32'd0);
      exp_q.delete();
      repeat (2) cyc();
      reset = 1'b1;
      kp_pressed = 1'b0;
      cyc();
      check("post_rst_level", 32'(fifo_level), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
